// File: rtl/cla_pkg.sv
// Package: cla_pkg
// Shared constants and helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  // Width of one carry-lookahead group.
  localparam int CLA_GRP = 4;

  typedef struct packed {
    logic g;
    logic p;
  } grp_gp_t;

  // Group generate/propagate of one 4-bit lookahead group from its per-bit g/p.
  function automatic grp_gp_t grp_gp(input logic [CLA_GRP-1:0] g,
                                     input logic [CLA_GRP-1:0] p);
    grp_gp_t r;
    r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r.p = &p;
    return r;
  endfunction

  // Legal configuration: SLICE is a whole number of groups and WIDTH a whole number of slices.
  function automatic bit cfg_ok(input int width, input int slice);
    return (slice > 0) && (slice % CLA_GRP == 0) && (width >= slice) && (width % slice == 0);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Module: cla_slice
// Combinational SLICE-bit carry-lookahead adder built from 4-bit lookahead groups.
// Reports the carry out of the slice and the carry into the slice MSB.
module cla_slice
  import cla_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             c_msb
);

  localparam int NGRP = SLICE / CLA_GRP;

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Carries: intra-group lookahead from the group carry-in, group carries from group G/P.
  always_comb begin
    logic                carry;
    logic [CLA_GRP-1:0]  gg;
    logic [CLA_GRP-1:0]  pp;
    grp_gp_t             gp;
    // NOTE: every variable gets a default before any conditional/loop so no latch is inferred.
    c     = '0;
    gg    = '0;
    pp    = '0;
    gp    = '0;
    // NOTE: combinational logic uses blocking '=' so 'carry' updates in order within the loop.
    carry = ci;
    for (int i = 0; i < NGRP; i++) begin
      gg = g[i*CLA_GRP +: CLA_GRP];
      pp = p[i*CLA_GRP +: CLA_GRP];
      c[i*CLA_GRP]     = carry;
      c[i*CLA_GRP + 1] = gg[0] | (pp[0] & carry);
      c[i*CLA_GRP + 2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & carry);
      c[i*CLA_GRP + 3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                       | (pp[2] & pp[1] & pp[0] & carry);
      gp    = grp_gp(gg, pp);
      carry = gp.g | (gp.p & carry);
    end
    c[SLICE] = carry;
  end

  assign s     = p ^ c[SLICE-1:0];
  assign co    = c[SLICE];
  assign c_msb = c[SLICE-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Module: cla_pipe_addsub
// Pipelined carry-lookahead adder/subtractor; stage k resolves bits [k*SLICE +: SLICE]
// with the carry registered by stage k-1. Operand skew and sum deskew triangles keep
// all bits of one result aligned. Global-stall valid/ready handshake.
// Optional feature: define CLA_SAT_EN to saturate s on signed overflow.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov,
  output logic             zero
);

  localparam int STAGES = WIDTH / SLICE;
  localparam bit CFG_OK = cfg_ok(WIDTH, SLICE);

  if (!CFG_OK) begin : g_bad_cfg
    $error("cla_pipe_addsub: WIDTH must be a multiple of SLICE and SLICE a multiple of 4");
  end

  // Whole pipeline moves together; it only freezes when a finished result is not taken.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SLICE;

    logic [WIDTH-1:LO]    op_a;
    logic [WIDTH-1:LO]    op_b;
    logic                 cin;
    logic                 vin;
    logic [SLICE-1:0]     sl_s;
    logic                 sl_co;
    logic                 sl_cm;
    logic [LO+SLICE-1:0]  sum_nxt;

    if (k == 0) begin : g_src
      assign op_a    = a;
      assign op_b    = b ^ {WIDTH{sub}};
      assign cin     = sub | ci;
      assign vin     = in_valid;
      assign sum_nxt = sl_s;
    end else begin : g_src
      assign op_a    = g_stage[k-1].g_reg.a_q;
      assign op_b    = g_stage[k-1].g_reg.b_q;
      assign cin     = g_stage[k-1].g_reg.c_q;
      assign vin     = g_stage[k-1].g_reg.v_q;
      assign sum_nxt = {sl_s, g_stage[k-1].g_reg.sum_q};
    end

    cla_slice #(.SLICE(SLICE)) u_slice (
      .a     (op_a[LO +: SLICE]),
      .b     (op_b[LO +: SLICE]),
      .ci    (cin),
      .s     (sl_s),
      .co    (sl_co),
      .c_msb (sl_cm)
    );

    if (k < STAGES - 1) begin : g_reg
      localparam int HI = LO + SLICE;

      logic [WIDTH-1:HI] a_q;
      logic [WIDTH-1:HI] b_q;
      logic [HI-1:0]     sum_q;
      logic              c_q;
      logic              v_q;
      logic              unused_cm;

      assign unused_cm = sl_cm;

      // Stage valid bit; reset discards whatever is in flight.
      always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking '<=' so every stage samples pre-edge values.
        if (!reset_n) v_q <= 1'b0;
        else if (adv) v_q <= vin;
      end

      // Skew/deskew data and inter-stage carry; qualified by v_q downstream.
      // NOTE: datapath registers carry no reset; a cleared valid bit already makes them don't-care.
      always_ff @(posedge clk) begin
        if (adv) begin
          a_q   <= op_a[WIDTH-1:HI];
          b_q   <= op_b[WIDTH-1:HI];
          sum_q <= sum_nxt;
          c_q   <= sl_co;
        end
      end
    end else begin : g_out
      logic [WIDTH-1:0] res;
      logic             ovf;

      assign ovf = sl_co ^ sl_cm;

      // Final result, clamped toward the operands' sign when saturation is built in.
      always_comb begin
        res = sum_nxt;
`ifdef CLA_SAT_EN
        if (ovf) res = op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
      end

      // Output register; data and flags load only with a valid result so they hold otherwise.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_valid <= 1'b0;
          s         <= '0;
          co        <= 1'b0;
          ov        <= 1'b0;
          zero      <= 1'b0;
        end else if (adv) begin
          out_valid <= vin;
          if (vin) begin
            s    <= res;
            co   <= sl_co;
            ov   <= ovf;
            zero <= (res == '0);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Testbench: tb_cla_pipe_addsub
// Three configurations (16/4, 32/8, 64/16; all four stages deep) run in lockstep
// from shared stimulus; results are compared against hand values and a reference model.
module tb_cla_pipe_addsub;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        ci;
    logic        sub;
  } txn_t;

  typedef struct packed {
    logic [63:0] s;
    logic        co;
    logic        ov;
    logic        zero;
  } res_t;

  localparam int STAGES = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        ci;
  logic        sub;

  logic        in_ready16, in_ready32, in_ready64;
  logic        out_valid16, out_valid32, out_valid64;
  logic [15:0] s16;
  logic [31:0] s32;
  logic [63:0] s64;
  logic        co16, co32, co64, ov16, ov32, ov64, zero16, zero32, zero64;

  int   n_checks = 0;
  int   n_pass   = 0;
  txn_t exp_q[$];

  always #5 clk = ~clk;

  cla_pipe_addsub #(.WIDTH(16), .SLICE(4)) u16 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a[15:0]), .b(b[15:0]), .ci(ci), .sub(sub),
    .out_valid(out_valid16), .out_ready(out_ready),
    .s(s16), .co(co16), .ov(ov16), .zero(zero16));

  cla_pipe_addsub #(.WIDTH(32), .SLICE(8)) u32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready32),
    .a(a[31:0]), .b(b[31:0]), .ci(ci), .sub(sub),
    .out_valid(out_valid32), .out_ready(out_ready),
    .s(s32), .co(co32), .ov(ov32), .zero(zero32));

  cla_pipe_addsub #(.WIDTH(64), .SLICE(16)) u64 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready64),
    .a(a), .b(b), .ci(ci), .sub(sub),
    .out_valid(out_valid64), .out_ready(out_ready),
    .s(s64), .co(co64), .ov(ov64), .zero(zero64));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: plain wide arithmetic, overflow from operand/result signs.
  function automatic res_t model(input int w, input txn_t t);
    logic [64:0] m, aa, bb, full;
    res_t r;
    m    = (65'd1 << w) - 65'd1;
    aa   = {1'b0, t.a} & m;
    bb   = {1'b0, (t.sub ? ~t.b : t.b)} & m;
    full = aa + bb + {64'd0, (t.sub | t.ci)};
    r.s  = full[63:0] & m[63:0];
    r.co = full[w];
    r.ov = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
`ifdef CLA_SAT_EN
    if (r.ov) r.s = aa[w-1] ? (64'd1 << (w-1)) : (m[63:0] >> 1);
`endif
    r.zero = (r.s == 64'd0);
    return r;
  endfunction

  task automatic cmp_all(input txn_t t);
    res_t r;
    r = model(16, t);
    check("s16", {48'd0, s16}, r.s);  check("co16", co16, r.co);
    check("ov16", ov16, r.ov);        check("zero16", zero16, r.zero);
    check("valid16", out_valid16, 1);
    r = model(32, t);
    check("s32", {32'd0, s32}, r.s);  check("co32", co32, r.co);
    check("ov32", ov32, r.ov);        check("zero32", zero32, r.zero);
    r = model(64, t);
    check("s64", s64, r.s);           check("co64", co64, r.co);
    check("ov64", ov64, r.ov);        check("zero64", zero64, r.zero);
    check("valid64", out_valid64, 1);
  endtask

  // Scoreboard: record accepts, compare every drained result in order.
  always @(negedge clk) begin : mon
    txn_t t;
    if (reset_n) begin
      if (in_valid && in_ready32) exp_q.push_back({a, b, ci, sub});
      if (out_valid32 && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else begin
          t = exp_q.pop_front();
          cmp_all(t);
        end
      end
    end
  end

  // Single op into an empty pipe: hand-computed 32-bit result and exact latency.
  task automatic run_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                        input logic tci, input logic tsub, input logic [31:0] es,
                        input logic eco, input logic eov, input logic ez);
    int  n;
    bit  seen;
    a = ta; b = tb_v; ci = tci; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    n = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid32) seen = 1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (!seen) check({tag, "_timeout"}, 0, 1);
    else begin
      check({tag, "_latency"}, n, STAGES);
      check({tag, "_s"}, s32, es);
      check({tag, "_co"}, co32, eco);
      check({tag, "_ov"}, ov32, eov);
      check({tag, "_zero"}, zero32, ez);
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] held;
    bit          acc;

    reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    a = 64'h1234; b = 64'd1; ci = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid32", out_valid32, 0);
    check("rst_valid16", out_valid16, 0);
    check("rst_valid64", out_valid64, 0);
    check("rst_s32", s32, 0);
    check("rst_co32", co32, 0);
    check("rst_zero32", zero32, 0);
    @(posedge clk); #1 in_valid = 1'b0; reset_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_wrap", 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
`ifdef CLA_SAT_EN
    run_op("ovf_pos", 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    run_op("sub_ovf", 64'h8000_0000, 64'd1, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    run_op("neg_ovf", 64'h8000_0000, 64'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
    run_op("ovf_pos", 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("sub_ovf", 64'h8000_0000, 64'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_op("neg_ovf", 64'h8000_0000, 64'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
`endif
    run_op("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("add_ci", 64'h1234_5678, 64'h0FED_CBA8, 1'b1, 1'b0, 32'h2222_2221, 1'b0, 1'b0, 1'b0);
    run_op("sub_ci_ign", 64'd10, 64'd10, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // Back-to-back stream with a 3-cycle output stall in the middle.
    fork
      begin : drv
        for (int i = 0; i < 8; i++) begin
          a = {$urandom, $urandom}; b = {$urandom, $urandom};
          ci = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
          in_valid = 1'b1;
          acc = 0;
          for (int g = 0; g < 20 && !acc; g++) begin
            @(negedge clk); acc = in_ready32;
            @(posedge clk); #1;
          end
          if (!acc) check("stream_accept_timeout", 0, 1);
        end
        in_valid = 1'b0;
      end
      begin : stall
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        held = s32;
        check("stall_valid", out_valid32, 1);
        for (int k = 0; k < 3; k++) begin
          if (k > 0) @(negedge clk);
          check("stall_in_ready32", in_ready32, 0);
          check("stall_in_ready16", in_ready16, 0);
          check("stall_in_ready64", in_ready64, 0);
          check("stall_hold_s32", s32, held);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
    check("stream_drained", exp_q.size(), 0);
    @(posedge clk); #1;

    // Mid-flight reset with STAGES-1 operations in the pipe.
    for (int i = 0; i < STAGES - 1; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; ci = 1'b0; sub = 1'(i);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset_n  = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_valid32", out_valid32, 0);
    check("midrst_valid64", out_valid64, 0);
    check("midrst_s32", s32, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (STAGES + 2) @(posedge clk);
    #1;
    run_op("post_rst", 64'h1234_5678, 64'h0FED_CBA8, 1'b1, 1'b0, 32'h2222_2221, 1'b0, 1'b0, 1'b0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
